// File: rtl/bet_action_controller_if.sv
// Purpose : bundles the betting-turn controller's engine/keyboard/display signals.
// Latency : none (wires only).
// Backpress: action_valid/action_ready handshake; the action is held until accepted.
// Ports   : master = game engine + keyboard side (drives table state, keycode, ready);
//           slave  = bet_action_controller (drives action and button-text values).
interface bet_action_controller_if #(
   parameter int AMT_W = 11
);
   logic [7:0]       keycode;
   logic             turn_start;
   logic [AMT_W-1:0] current_bet;
   logic [AMT_W-1:0] player_contrib;
   logic [AMT_W-1:0] player_stack;
   logic [AMT_W-1:0] big_blind;
   logic             action_ready;
   logic             action_valid;
   logic [2:0]       action_code;
   logic [AMT_W-1:0] action_amount;
   logic             if_BetCheck;
   logic [AMT_W-1:0] min_bet_or_raise;
   logic [AMT_W-1:0] call_size;
   logic             turn_active;

   modport master (
      output keycode, turn_start, current_bet, player_contrib, player_stack, big_blind, action_ready,
      input  action_valid, action_code, action_amount, if_BetCheck, min_bet_or_raise, call_size,
             turn_active
   );

   modport slave (
      input  keycode, turn_start, current_bet, player_contrib, player_stack, big_blind, action_ready,
      output action_valid, action_code, action_amount, if_BetCheck, min_bet_or_raise, call_size,
             turn_active
   );
endinterface

// File: rtl/bet_action_controller.sv
// Purpose : sequences the human player's betting turn: latches table state, derives the
//           Check/Bet vs Call/Raise mode, call amount and adjustable bet, decodes key presses.
// Latency : key press edge to action_valid = 2 clocks; table latch 1 clock after turn_start.
// Backpress: action code/amount held stable while action_valid && !action_ready.
// Ports   : Clk, Reset_n (synchronous, active-low); bus = slave modport of bet_action_controller_if.
// Option  : define TURN_TIMEOUT_EN to force CHECK (Bet mode) or FOLD (Raise mode) after
//           TURN_CYCLES clocks waiting for a key; without it the turn waits indefinitely.
module bet_action_controller #(
   parameter int AMT_W    = 11,
   parameter int MAX_DISP = 9999
`ifdef TURN_TIMEOUT_EN
   ,
   parameter logic [31:0] TURN_CYCLES = 32'd500_000_000
`endif
) (
   input logic                    Clk,
   input logic                    Reset_n,
   bet_action_controller_if.slave bus
);
   // One extra bit so differences and sums never wrap before clamping.
   localparam int CW = AMT_W + 1;
   // Display ceiling at the working width; saturates if MAX_DISP exceeds what CW can hold.
   localparam logic [CW-1:0] MAX_C = (MAX_DISP >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(MAX_DISP);

   localparam logic [7:0] KEY_F  = 8'h09;
   localparam logic [7:0] KEY_C  = 8'h06;
   localparam logic [7:0] KEY_B  = 8'h05;
   localparam logic [7:0] KEY_R  = 8'h15;
   localparam logic [7:0] KEY_UP = 8'h52;
   localparam logic [7:0] KEY_DN = 8'h51;

   localparam logic [2:0] ACT_FOLD  = 3'd1;
   localparam logic [2:0] ACT_CHECK = 3'd2;
   localparam logic [2:0] ACT_CALL  = 3'd3;
   localparam logic [2:0] ACT_BET   = 3'd4;
   localparam logic [2:0] ACT_RAISE = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_WAIT_KEY, S_ISSUE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       key_q, key_d, key_prev_q, key_prev_d;
   logic             bet_mode_q, bet_mode_d;
   logic [AMT_W-1:0] call_q, call_d;
   logic [AMT_W-1:0] sel_q, sel_d;
   logic [AMT_W-1:0] floor_q, floor_d;
   logic [AMT_W-1:0] ceil_q, ceil_d;
   logic [AMT_W-1:0] step_q, step_d;
   logic [AMT_W-1:0] amt_q, amt_d;
   logic [2:0]       code_q, code_d;
   logic             vld_q, vld_d;
   logic             active_q, active_d;
`ifdef TURN_TIMEOUT_EN
   logic [31:0]      cnt_q, cnt_d;
`endif

   logic [CW-1:0]    cb_w, pc_w, stk_w, bb_w;
   logic [CW-1:0]    diff_w, cap_w, call_w, lo_w, up_w, dn_w;
   logic             press;
   logic             take;
   logic [2:0]       take_code;
   logic [AMT_W-1:0] take_amt;

   function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   always_comb begin
      state_d    = state_q;
      key_d      = bus.keycode;
      key_prev_d = key_q;
      bet_mode_d = bet_mode_q;
      call_d     = call_q;
      sel_d      = sel_q;
      floor_d    = floor_q;
      ceil_d     = ceil_q;
      step_d     = step_q;
      code_d     = code_q;
      amt_d      = amt_q;
      vld_d      = vld_q;
      active_d   = active_q;
      take       = 1'b0;
      take_code  = ACT_FOLD;
      take_amt   = '0;
`ifdef TURN_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif

      cb_w   = {1'b0, bus.current_bet};
      pc_w   = {1'b0, bus.player_contrib};
      stk_w  = {1'b0, bus.player_stack};
      bb_w   = {1'b0, bus.big_blind};
      diff_w = (cb_w > pc_w) ? cb_w - pc_w : '0;
      cap_w  = min2(stk_w, MAX_C);
      call_w = min2(diff_w, cap_w);
      lo_w   = (diff_w == '0) ? min2(bb_w, cap_w) : min2(call_w + bb_w, cap_w);

      // Up/Down candidates use the step and bounds captured at latch time.
      up_w   = min2({1'b0, sel_q} + {1'b0, step_q}, {1'b0, ceil_q});
      dn_w   = ({1'b0, sel_q} >= {1'b0, floor_q} + {1'b0, step_q}) ?
               {1'b0, sel_q} - {1'b0, step_q} : {1'b0, floor_q};

      // Press edge on the registered key pair, so held keys never repeat.
      press  = (key_q != 8'h00) && (key_prev_q == 8'h00);

      case (state_q)
         S_IDLE: begin
            if (bus.turn_start) state_d = S_LATCH;
         end
         S_LATCH: begin
            bet_mode_d = (diff_w == '0);
            call_d     = call_w[AMT_W-1:0];
            sel_d      = lo_w[AMT_W-1:0];
            floor_d    = lo_w[AMT_W-1:0];
            ceil_d     = cap_w[AMT_W-1:0];
            step_d     = bus.big_blind;
            active_d   = 1'b1;
            state_d    = S_WAIT_KEY;
`ifdef TURN_TIMEOUT_EN
            cnt_d      = '0;
`endif
         end
         S_WAIT_KEY: begin
            if (press) begin
               case (key_q)
                  KEY_UP: sel_d = up_w[AMT_W-1:0];
                  KEY_DN: sel_d = dn_w[AMT_W-1:0];
                  KEY_F: begin
                     take      = 1'b1;
                     take_code = ACT_FOLD;
                  end
                  KEY_C: begin
                     take      = 1'b1;
                     take_code = bet_mode_q ? ACT_CHECK : ACT_CALL;
                     take_amt  = bet_mode_q ? '0 : call_q;
                  end
                  KEY_B: begin
                     if (bet_mode_q) begin
                        take      = 1'b1;
                        take_code = ACT_BET;
                        take_amt  = sel_q;
                     end
                  end
                  KEY_R: begin
                     if (!bet_mode_q) begin
                        take      = 1'b1;
                        take_code = ACT_RAISE;
                        take_amt  = sel_q;
                     end
                  end
                  default: ;
               endcase
            end
`ifdef TURN_TIMEOUT_EN
            // A press edge pre-empts the timeout; the counter then parks at the
            // limit so the timeout fires on the next press-free cycle.
            else if (cnt_q >= TURN_CYCLES - 32'd1) begin
               take      = 1'b1;
               take_code = bet_mode_q ? ACT_CHECK : ACT_FOLD;
            end
            if (cnt_q < TURN_CYCLES - 32'd1) cnt_d = cnt_q + 32'd1;
`endif
            if (take) begin
               vld_d   = 1'b1;
               code_d  = take_code;
               amt_d   = take_amt;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (vld_q && bus.action_ready) begin
               vld_d    = 1'b0;
               active_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         key_q      <= '0;
         key_prev_q <= '0;
         bet_mode_q <= 1'b1;
         call_q     <= '0;
         sel_q      <= '0;
         floor_q    <= '0;
         ceil_q     <= '0;
         step_q     <= '0;
         code_q     <= '0;
         amt_q      <= '0;
         vld_q      <= 1'b0;
         active_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         key_prev_q <= key_prev_d;
         bet_mode_q <= bet_mode_d;
         call_q     <= call_d;
         sel_q      <= sel_d;
         floor_q    <= floor_d;
         ceil_q     <= ceil_d;
         step_q     <= step_d;
         code_q     <= code_d;
         amt_q      <= amt_d;
         vld_q      <= vld_d;
         active_q   <= active_d;
`ifdef TURN_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign bus.action_valid     = vld_q;
   assign bus.action_code      = code_q;
   assign bus.action_amount    = amt_q;
   assign bus.if_BetCheck      = bet_mode_q;
   assign bus.min_bet_or_raise = sel_q;
   assign bus.call_size        = call_q;
   assign bus.turn_active      = active_q;

endmodule

// File: tb/tb_bet_action_controller.sv
`timescale 1ns/1ps
module tb_bet_action_controller;
   localparam int AMT_W    = 11;
   localparam int MAX_DISP = 9999;
   localparam logic [7:0] K_F  = 8'h09;
   localparam logic [7:0] K_C  = 8'h06;
   localparam logic [7:0] K_B  = 8'h05;
   localparam logic [7:0] K_R  = 8'h15;
   localparam logic [7:0] K_UP = 8'h52;
   localparam logic [7:0] K_DN = 8'h51;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   // Reference model of the current turn, from the betting rules.
   int m_call, m_sel, m_floor, m_ceil, m_bb;
   bit m_bet;

   bet_action_controller_if #(.AMT_W(AMT_W)) bus ();

   bet_action_controller #(
      .AMT_W(AMT_W),
      .MAX_DISP(MAX_DISP)
`ifdef TURN_TIMEOUT_EN
      ,
      .TURN_CYCLES(32'd16)
`endif
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic model_latch(input int cb, input int pc, input int stk, input int bb);
      int diff;
      diff    = (cb > pc) ? cb - pc : 0;
      m_bet   = (diff == 0);
      m_ceil  = imin(stk, MAX_DISP);
      m_call  = imin(diff, m_ceil);
      m_floor = m_bet ? imin(bb, m_ceil) : imin(m_call + bb, m_ceil);
      m_sel   = m_floor;
      m_bb    = bb;
   endtask

   task automatic model_key(input logic [7:0] k, output bit act, output int code, output int amt);
      act = 0; code = 0; amt = 0;
      if (k == K_UP) m_sel = imin(m_sel + m_bb, m_ceil);
      else if (k == K_DN) m_sel = (m_sel - m_bb < m_floor) ? m_floor : m_sel - m_bb;
      else if (k == K_F) begin act = 1; code = 1; end
      else if (k == K_C) begin act = 1; code = m_bet ? 2 : 3; amt = m_bet ? 0 : m_call; end
      else if (k == K_B && m_bet) begin act = 1; code = 4; amt = m_sel; end
      else if (k == K_R && !m_bet) begin act = 1; code = 5; amt = m_sel; end
   endtask

   task automatic start_turn(input int cb, input int pc, input int stk, input int bb);
      bus.current_bet    = AMT_W'(cb);
      bus.player_contrib = AMT_W'(pc);
      bus.player_stack   = AMT_W'(stk);
      bus.big_blind      = AMT_W'(bb);
      bus.turn_start     = 1'b1;
      tick();
      bus.turn_start     = 1'b0;
      tick();
      model_latch(cb, pc, stk, bb);
   endtask

   task automatic press(input logic [7:0] k, input int hold);
      bus.keycode = k;
      repeat (hold) tick();
      bus.keycode = 8'h00;
      tick();
   endtask

   task automatic wait_valid(input int budget, output bit seen);
      seen = bus.action_valid;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         seen = bus.action_valid;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({bus.action_valid, bus.action_code, bus.action_amount, bus.if_BetCheck,
           bus.min_bet_or_raise, bus.call_size, bus.turn_active} !==
          {1'b0, 3'd0, {AMT_W{1'b0}}, 1'b1, {AMT_W{1'b0}}, {AMT_W{1'b0}}, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: got vld=%b code=%0d amt=%0d bc=%b sel=%0d call=%0d act=%b want 0,0,0,1,0,0,0",
                  bus.action_valid, bus.action_code, bus.action_amount, bus.if_BetCheck,
                  bus.min_bet_or_raise, bus.call_size, bus.turn_active);
      end
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_check_mode();
      bus.action_ready = 1'b1;
      start_turn(0, 0, 500, 20);
      tests_run++;
      if ({bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise, bus.turn_active} !==
          {1'b1, AMT_W'(0), AMT_W'(20), 1'b1}) begin
         tests_failed++;
         $display("FAIL check_latch: got bc=%b call=%0d sel=%0d act=%b want 1,0,20,1",
                  bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise, bus.turn_active);
      end
      press(K_C, 1);
      tests_run++;
      if ({bus.action_valid, bus.action_code, bus.action_amount} !== {1'b1, 3'd2, AMT_W'(0)}) begin
         tests_failed++;
         $display("FAIL check_action: got vld=%b code=%0d amt=%0d want 1,2,0",
                  bus.action_valid, bus.action_code, bus.action_amount);
      end
      tick();
      tests_run++;
      if ({bus.action_valid, bus.turn_active} !== 2'b00) begin
         tests_failed++;
         $display("FAIL check_one_cycle: got vld=%b act=%b want 0,0", bus.action_valid, bus.turn_active);
      end
      bus.action_ready = 1'b0;
   endtask

   task automatic test_raise_adjust();
      start_turn(100, 20, 500, 20);
      tests_run++;
      if ({bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise} !== {1'b0, AMT_W'(80), AMT_W'(100)}) begin
         tests_failed++;
         $display("FAIL raise_latch: got bc=%b call=%0d sel=%0d want 0,80,100",
                  bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise);
      end
      repeat (3) press(K_UP, 1);
      tests_run++;
      if (bus.min_bet_or_raise !== AMT_W'(160)) begin
         tests_failed++;
         $display("FAIL raise_up3: got %0d want 160", bus.min_bet_or_raise);
      end
      repeat (5) press(K_DN, 1);
      tests_run++;
      if (bus.min_bet_or_raise !== AMT_W'(100)) begin
         tests_failed++;
         $display("FAIL raise_down5: got %0d want 100", bus.min_bet_or_raise);
      end
      press(K_R, 1);
      tests_run++;
      if ({bus.action_valid, bus.action_code, bus.action_amount} !== {1'b1, 3'd5, AMT_W'(100)}) begin
         tests_failed++;
         $display("FAIL raise_action: got vld=%b code=%0d amt=%0d want 1,5,100",
                  bus.action_valid, bus.action_code, bus.action_amount);
      end
      bus.action_ready = 1'b1;
      tick();
      bus.action_ready = 1'b0;
   endtask

   task automatic test_short_stack();
      start_turn(300, 0, 150, 20);
      tests_run++;
      if ({bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise} !== {1'b0, AMT_W'(150), AMT_W'(150)}) begin
         tests_failed++;
         $display("FAIL short_latch: got bc=%b call=%0d sel=%0d want 0,150,150",
                  bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise);
      end
      press(K_UP, 1);
      tests_run++;
      if (bus.min_bet_or_raise !== AMT_W'(150)) begin
         tests_failed++;
         $display("FAIL short_up_ceiling: got %0d want 150", bus.min_bet_or_raise);
      end
      press(K_C, 1);
      tests_run++;
      if ({bus.action_valid, bus.action_code, bus.action_amount} !== {1'b1, 3'd3, AMT_W'(150)}) begin
         tests_failed++;
         $display("FAIL short_call: got vld=%b code=%0d amt=%0d want 1,3,150",
                  bus.action_valid, bus.action_code, bus.action_amount);
      end
      bus.action_ready = 1'b1;
      tick();
      bus.action_ready = 1'b0;
   endtask

   task automatic test_back_to_back_hold();
      int vcnt, hs, bad;
      bit hs_pending;
      vcnt = 0; hs = 0; bad = 0;
      bus.action_ready = 1'b0;
      start_turn(0, 0, 500, 20);
      bus.keycode = K_B;
      for (int i = 0; i < 16; i++) begin
         hs_pending = bus.action_valid && bus.action_ready;
         tick();
         if (hs_pending) hs++;
         if (i == 9) bus.keycode = 8'h00;
         if (bus.action_valid) begin
            vcnt++;
            if (bus.action_code !== 3'd4 || bus.action_amount !== AMT_W'(20)) bad++;
            if (vcnt == 6) bus.action_ready = 1'b1;
         end else begin
            bus.action_ready = 1'b0;
         end
      end
      tests_run++;
      if (vcnt != 6 || hs != 1 || bad != 0) begin
         tests_failed++;
         $display("FAIL hold_single_bet: got valid_cycles=%0d handshakes=%0d unstable=%0d want 6,1,0",
                  vcnt, hs, bad);
      end
      tests_run++;
      if ({bus.action_valid, bus.turn_active} !== 2'b00) begin
         tests_failed++;
         $display("FAIL hold_back_idle: got vld=%b act=%b want 0,0", bus.action_valid, bus.turn_active);
      end
      bus.action_ready = 1'b0;
   endtask

   task automatic test_reset_in_issue();
      bit seen;
      bus.action_ready = 1'b0;
      start_turn(100, 20, 500, 20);
      press(K_F, 1);
      tests_run++;
      if ({bus.action_valid, bus.action_code} !== {1'b1, 3'd1}) begin
         tests_failed++;
         $display("FAIL rst_issue_pre: got vld=%b code=%0d want 1,1", bus.action_valid, bus.action_code);
      end
      Reset_n = 1'b0;
      tick();
      tests_run++;
      if ({bus.action_valid, bus.action_code, bus.action_amount, bus.if_BetCheck,
           bus.min_bet_or_raise, bus.call_size, bus.turn_active} !==
          {1'b0, 3'd0, {AMT_W{1'b0}}, 1'b1, {AMT_W{1'b0}}, {AMT_W{1'b0}}, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_issue_state: got vld=%b code=%0d amt=%0d bc=%b sel=%0d call=%0d act=%b want 0,0,0,1,0,0,0",
                  bus.action_valid, bus.action_code, bus.action_amount, bus.if_BetCheck,
                  bus.min_bet_or_raise, bus.call_size, bus.turn_active);
      end
      Reset_n = 1'b1;
      tick();
      press(K_C, 1);
      wait_valid(6, seen);
      tests_run++;
      if (seen || bus.turn_active !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_no_turn_key: got valid_seen=%b act=%b want 0,0", seen, bus.turn_active);
      end
   endtask

   task automatic test_random();
      int cb, pc, stk, bb, code, amt, delay, r, presses;
      bit act, seen;
      logic [7:0] k;
      for (int t = 0; t < 40; t++) begin
         cb  = $urandom_range(0, 2047);
         pc  = ($urandom_range(0, 3) == 0) ? cb : $urandom_range(0, 2047);
         stk = $urandom_range(0, 2047);
         bb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2047) : $urandom_range(1, 300);
         bus.action_ready = 1'b0;
         start_turn(cb, pc, stk, bb);
         tests_run++;
         if ({bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise, bus.turn_active} !==
             {m_bet, AMT_W'(m_call), AMT_W'(m_sel), 1'b1}) begin
            tests_failed++;
            $display("FAIL rand_latch t=%0d: got bc=%b call=%0d sel=%0d act=%b want %b,%0d,%0d,1 (cb=%0d pc=%0d stk=%0d bb=%0d)",
                     t, bus.if_BetCheck, bus.call_size, bus.min_bet_or_raise, bus.turn_active,
                     m_bet, m_call, m_sel, cb, pc, stk, bb);
         end
         act = 0;
         presses = 0;
         while (!act) begin
            r = $urandom_range(0, 9);
            k = (r < 3) ? K_UP : (r < 5) ? K_DN : (r == 5) ? K_F : (r == 6) ? K_C :
                (r == 7) ? K_B : (r == 8) ? K_R : 8'h2C;
            if (presses >= 12) k = K_F;
            presses++;
            press(k, $urandom_range(1, 3));
            model_key(k, act, code, amt);
            if (!act) begin
               tests_run++;
               if ({bus.action_valid, bus.min_bet_or_raise} !== {1'b0, AMT_W'(m_sel)}) begin
                  tests_failed++;
                  $display("FAIL rand_adjust t=%0d key=%h: got vld=%b sel=%0d want 0,%0d",
                           t, k, bus.action_valid, bus.min_bet_or_raise, m_sel);
               end
               if ($urandom_range(0, 2) == 0) tick();
            end
         end
         wait_valid(8, seen);
         tests_run++;
         if (!seen || bus.action_code !== 3'(code) || bus.action_amount !== AMT_W'(amt)) begin
            tests_failed++;
            $display("FAIL rand_action t=%0d: got vld=%b code=%0d amt=%0d want 1,%0d,%0d",
                     t, seen, bus.action_code, bus.action_amount, code, amt);
         end
         delay = $urandom_range(0, 3);
         for (int d = 0; d < delay; d++) begin
            tick();
            tests_run++;
            if ({bus.action_valid, bus.action_code, bus.action_amount} !== {1'b1, 3'(code), AMT_W'(amt)}) begin
               tests_failed++;
               $display("FAIL rand_hold t=%0d: got vld=%b code=%0d amt=%0d want 1,%0d,%0d",
                        t, bus.action_valid, bus.action_code, bus.action_amount, code, amt);
            end
         end
         bus.action_ready = 1'b1;
         tick();
         bus.action_ready = 1'b0;
         tests_run++;
         if ({bus.action_valid, bus.turn_active} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rand_done t=%0d: got vld=%b act=%b want 0,0", t, bus.action_valid, bus.turn_active);
         end
      end
   endtask

`ifdef TURN_TIMEOUT_EN
   task automatic test_timeout();
      bit early;
      early = 0;
      bus.action_ready = 1'b0;
      start_turn(100, 20, 500, 20);
      for (int i = 1; i < 16; i++) begin
         tick();
         if (bus.action_valid) early = 1;
      end
      tick();
      tests_run++;
      if (early || {bus.action_valid, bus.action_code, bus.action_amount} !== {1'b1, 3'd1, AMT_W'(0)}) begin
         tests_failed++;
         $display("FAIL timeout_fold: got early=%b vld=%b code=%0d amt=%0d want 0,1,1,0",
                  early, bus.action_valid, bus.action_code, bus.action_amount);
      end
      bus.action_ready = 1'b1;
      tick();
      bus.action_ready = 1'b0;
      start_turn(0, 0, 500, 20);
      repeat (14) tick();
      press(K_F, 1);
      tests_run++;
      if ({bus.action_valid, bus.action_code, bus.action_amount} !== {1'b1, 3'd1, AMT_W'(0)}) begin
         tests_failed++;
         $display("FAIL timeout_key_wins: got vld=%b code=%0d amt=%0d want 1,1,0",
                  bus.action_valid, bus.action_code, bus.action_amount);
      end
      bus.action_ready = 1'b1;
      tick();
      bus.action_ready = 1'b0;
   endtask
`else
   task automatic test_no_timeout();
      bit seen;
      bus.action_ready = 1'b0;
      start_turn(100, 20, 500, 20);
      wait_valid(40, seen);
      tests_run++;
      if (seen || bus.turn_active !== 1'b1) begin
         tests_failed++;
         $display("FAIL no_timeout_wait: got valid_seen=%b act=%b want 0,1", seen, bus.turn_active);
      end
      press(K_F, 1);
      tests_run++;
      if ({bus.action_valid, bus.action_code} !== {1'b1, 3'd1}) begin
         tests_failed++;
         $display("FAIL no_timeout_fold: got vld=%b code=%0d want 1,1", bus.action_valid, bus.action_code);
      end
      bus.action_ready = 1'b1;
      tick();
      bus.action_ready = 1'b0;
   endtask
`endif

   initial begin
      bus.keycode        = 8'h00;
      bus.turn_start     = 1'b0;
      bus.current_bet    = '0;
      bus.player_contrib = '0;
      bus.player_stack   = '0;
      bus.big_blind      = '0;
      bus.action_ready   = 1'b0;
      test_reset();
      test_check_mode();
      test_raise_adjust();
      test_short_stack();
      test_back_to_back_hold();
      test_reset_in_issue();
      test_random();
`ifdef TURN_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
